// File: rtl/quiz_answer_judge.sv
// rtl/quiz_answer_judge.sv - quiz game controller: steers the LCG, captures a question, judges BCD answers
// and keeps score over a fixed number of rounds with a per-question time limit.
module quiz_answer_judge #(
  parameter int ROUNDS        = 8,
  parameter int TIME_LIMIT    = 500,
  parameter int ROLL_CYCLES   = 3,
  parameter int RESULT_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_btn,
  input  logic       submit_btn,
  input  logic [3:0] ans_tens,
  input  logic [3:0] ans_ones,
  input  logic [3:0] random_num,
  output logic [1:0] lcg_state,
  output logic [3:0] question,
  output logic       correct,
  output logic       wrong,
  output logic       timeout,
  output logic [3:0] score,
  output logic [3:0] round,
  output logic       done
);

  localparam int TW = $clog2(TIME_LIMIT) + 1;
  localparam int RW = $clog2(RESULT_CYCLES) + 1;
  localparam int LW = $clog2(ROLL_CYCLES) + 1;

  localparam logic [TW-1:0] TIME_LAST   = TW'(TIME_LIMIT - 1);
  localparam logic [RW-1:0] RESULT_LAST = RW'(RESULT_CYCLES - 1);
  localparam logic [LW-1:0] ROLL_LAST   = LW'(ROLL_CYCLES - 1);
  localparam logic [3:0]    ROUNDS_L    = 4'(ROUNDS);

  localparam logic [1:0] LCG_LATCH = 2'd0;
  localparam logic [1:0] LCG_ROLL  = 2'd1;
  localparam logic [1:0] LCG_HOLD  = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ROLL,
    S_LATCH,
    S_ASK,
    S_WAIT,
    S_RESULT,
    S_DONE
  } state_t;

  state_t        state_q;
  logic [1:0]    lcg_q;
  logic [3:0]    question_q;
  logic          correct_q;
  logic          wrong_q;
  logic          timeout_q;
  logic [3:0]    score_q;
  logic [3:0]    round_q;
  logic          done_q;
  logic [TW-1:0] timer_q;
  logic [RW-1:0] res_cnt_q;
  logic [LW-1:0] roll_cnt_q;

  logic [3:0] exp_tens;
  logic [3:0] exp_ones;
  logic       ans_bcd;
  logic       ans_ok;
  logic [3:0] score_d;
  logic [3:0] round_d;

  // The question is binary 0..15; the player types it as two BCD digits.
  always_comb begin
    exp_tens = (question_q >= 4'd10) ? 4'd1 : 4'd0;
    exp_ones = (question_q >= 4'd10) ? (question_q - 4'd10) : question_q;
    ans_bcd  = (ans_tens <= 4'd1) && (ans_ones <= 4'd9);
    ans_ok   = ans_bcd && (ans_tens == exp_tens) && (ans_ones == exp_ones);
    score_d  = score_q + {3'b000, ans_ok};
    round_d  = round_q + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      lcg_q      <= LCG_ROLL;
      question_q <= 4'd0;
      correct_q  <= 1'b0;
      wrong_q    <= 1'b0;
      timeout_q  <= 1'b0;
      score_q    <= 4'd0;
      round_q    <= 4'd0;
      done_q     <= 1'b0;
      timer_q    <= '0;
      res_cnt_q  <= '0;
      roll_cnt_q <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_btn) begin
            score_q <= 4'd0;
            round_q <= 4'd0;
            done_q  <= 1'b0;
            lcg_q   <= LCG_LATCH;
            state_q <= S_LATCH;
          end
        end
        S_ROLL: begin
          if (roll_cnt_q == ROLL_LAST) begin
            lcg_q   <= LCG_LATCH;
            state_q <= S_LATCH;
          end else begin
            roll_cnt_q <= roll_cnt_q + LW'(1);
          end
        end
        S_LATCH: begin
          lcg_q   <= LCG_HOLD;
          state_q <= S_ASK;
        end
        S_ASK: begin
          // random_num is valid one cycle after the latch command.
          question_q <= random_num;
          timer_q    <= '0;
          state_q    <= S_WAIT;
        end
        S_WAIT: begin
          timer_q <= timer_q + TW'(1);
          if (submit_btn) begin
            correct_q <= ans_ok;
            wrong_q   <= ~ans_ok;
            score_q   <= score_d;
            round_q   <= round_d;
            res_cnt_q <= '0;
            state_q   <= S_RESULT;
          end else if (timer_q == TIME_LAST) begin
            timeout_q <= 1'b1;
            round_q   <= round_d;
            res_cnt_q <= '0;
            state_q   <= S_RESULT;
          end
        end
        S_RESULT: begin
          if (res_cnt_q == RESULT_LAST) begin
            correct_q <= 1'b0;
            wrong_q   <= 1'b0;
            timeout_q <= 1'b0;
            lcg_q     <= LCG_ROLL;
            if (round_q == ROUNDS_L) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              roll_cnt_q <= '0;
              state_q    <= S_ROLL;
            end
          end else begin
            res_cnt_q <= res_cnt_q + RW'(1);
          end
        end
        default: begin
          lcg_q   <= LCG_ROLL;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign lcg_state = lcg_q;
  assign question  = question_q;
  assign correct   = correct_q;
  assign wrong     = wrong_q;
  assign timeout   = timeout_q;
  assign score     = score_q;
  assign round     = round_q;
  assign done      = done_q;

endmodule

// File: tb/tb_quiz_answer_judge.sv
// tb/tb_quiz_answer_judge.sv - directed and randomized bench for quiz_answer_judge against a game-rule model.
module tb_quiz_answer_judge;

  localparam int ROUNDS        = 8;
  localparam int TIME_LIMIT    = 500;
  localparam int ROLL_CYCLES   = 3;
  localparam int RESULT_CYCLES = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_btn = 1'b0;
  logic       submit_btn = 1'b0;
  logic [3:0] ans_tens = 4'd0;
  logic [3:0] ans_ones = 4'd0;
  logic [3:0] random_num = 4'd0;
  logic [1:0] lcg_state;
  logic [3:0] question;
  logic       correct;
  logic       wrong;
  logic       timeout;
  logic [3:0] score;
  logic [3:0] round;
  logic       done;

  int         checks = 0;
  int         errors = 0;
  logic       fix_en = 1'b0;
  logic [3:0] fix_val = 4'd0;

  quiz_answer_judge #(
    .ROUNDS(ROUNDS),
    .TIME_LIMIT(TIME_LIMIT),
    .ROLL_CYCLES(ROLL_CYCLES),
    .RESULT_CYCLES(RESULT_CYCLES)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start_btn(start_btn),
    .submit_btn(submit_btn),
    .ans_tens(ans_tens),
    .ans_ones(ans_ones),
    .random_num(random_num),
    .lcg_state(lcg_state),
    .question(question),
    .correct(correct),
    .wrong(wrong),
    .timeout(timeout),
    .score(score),
    .round(round),
    .done(done)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(negedge clk);
    random_num = fix_en ? fix_val : 4'($urandom_range(0, 15));
  end

  // Game model: phase plus cycles left/elapsed; verdict 0 none, 1 correct, 2 wrong, 3 timeout.
  typedef enum int {M_IDLE, M_ROLL, M_LATCH, M_ASK, M_WAIT, M_RESULT, M_DONE} mphase_t;
  mphase_t m_phase = M_IDLE;
  int      m_q = 0;
  int      m_score = 0;
  int      m_round = 0;
  int      m_verdict = 0;
  int      m_elapsed = 0;
  int      m_left = 0;
  bit      m_valid = 1'b0;

  initial forever begin
    @(posedge clk);
    if (!rst_n) begin
      m_phase = M_IDLE; m_q = 0; m_score = 0; m_round = 0; m_verdict = 0; m_valid = 1'b1;
    end else begin
      case (m_phase)
        M_IDLE, M_DONE: if (start_btn) begin m_score = 0; m_round = 0; m_phase = M_LATCH; end
        M_ROLL: begin m_left--; if (m_left == 0) m_phase = M_LATCH; end
        M_LATCH: m_phase = M_ASK;
        M_ASK: begin m_q = int'(random_num); m_elapsed = 0; m_phase = M_WAIT; end
        M_WAIT: begin
          m_elapsed++;
          if (submit_btn)
            m_verdict = (int'(ans_tens) <= 9 && int'(ans_ones) <= 9 &&
                         int'(ans_tens) * 10 + int'(ans_ones) == m_q) ? 1 : 2;
          else if (m_elapsed == TIME_LIMIT)
            m_verdict = 3;
          if (m_verdict != 0) begin
            m_round++;
            if (m_verdict == 1) m_score++;
            m_left = RESULT_CYCLES;
            m_phase = M_RESULT;
          end
        end
        M_RESULT: begin
          m_left--;
          if (m_left == 0) begin
            m_verdict = 0;
            m_phase = (m_round == ROUNDS) ? M_DONE : M_ROLL;
            m_left = ROLL_CYCLES;
          end
        end
        default: m_phase = M_IDLE;
      endcase
    end
  end

  initial forever begin
    logic [1:0] exp_lcg;
    @(posedge clk);
    #1;
    if (m_valid) begin
      case (m_phase)
        M_LATCH: exp_lcg = 2'd0;
        M_ASK, M_WAIT, M_RESULT: exp_lcg = 2'd2;
        default: exp_lcg = 2'd1;
      endcase
      checks++;
      if (lcg_state !== exp_lcg || question !== 4'(m_q) || correct !== (m_verdict == 1) ||
          wrong !== (m_verdict == 2) || timeout !== (m_verdict == 3) || score !== 4'(m_score) ||
          round !== 4'(m_round) || done !== (m_phase == M_DONE)) begin
        errors++;
        $display("FAIL model_compare t=%0t actual lcg=%0d q=%0d c/w/t=%b%b%b score=%0d round=%0d done=%b required lcg=%0d q=%0d verdict=%0d score=%0d round=%0d done=%0d",
                 $time, lcg_state, question, correct, wrong, timeout, score, round, done,
                 exp_lcg, m_q, m_verdict, m_score, m_round, int'(m_phase == M_DONE));
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_phase(input mphase_t p, input string name);
    int n = 0;
    while (m_phase != p && n < 2000) begin
      tick();
      n++;
    end
    if (m_phase != p) begin
      checks++;
      errors++;
      $display("FAIL %s wait_expired actual_phase=%0d required_phase=%0d", name, m_phase, p);
    end
  endtask

  task automatic do_round(input int q, input int tens, input int ones, input int delay, input string name);
    fix_val = 4'(q);
    fix_en = 1'b1;
    wait_phase(M_WAIT, name);
    repeat (delay) tick();
    ans_tens = 4'(tens);
    ans_ones = 4'(ones);
    submit_btn = 1'b1;
    tick();
    submit_btn = 1'b0;
  endtask

  task automatic check_reset_values(input string name);
    check({name, "_lcg"}, int'(lcg_state), 1);
    check({name, "_question"}, int'(question), 0);
    check({name, "_score"}, int'(score), 0);
    check({name, "_round"}, int'(round), 0);
    check({name, "_flags"}, int'({correct, wrong, timeout}), 0);
    check({name, "_done"}, int'(done), 0);
  endtask

  initial begin
    int n;
    repeat (2) tick();
    rst_n = 1'b1;
    check_reset_values("reset");
    repeat (5) tick();
    check("idle_hold_lcg", int'(lcg_state), 1);
    check("idle_hold_round", int'(round), 0);

    // Round 1: question 13 answered "13".
    fix_val = 4'd13;
    fix_en = 1'b1;
    start_btn = 1'b1;
    tick();
    start_btn = 1'b0;
    check("seq_latch_lcg", int'(lcg_state), 0);
    tick();
    check("seq_ask_lcg", int'(lcg_state), 2);
    tick();
    check("seq_wait_lcg", int'(lcg_state), 2);
    ans_tens = 4'd1;
    ans_ones = 4'd3;
    submit_btn = 1'b1;
    tick();
    submit_btn = 1'b0;
    check("r1_question", int'(question), 13);
    check("r1_score", int'(score), 1);
    check("r1_round", int'(round), 1);
    n = 0;
    while (correct === 1'b1 && n < 10) begin
      n++;
      tick();
    end
    check("r1_correct_cycles", n, 4);

    do_round(7, 0, 8, 2, "r2");
    check("r2_wrong", int'(wrong), 1);
    check("r2_score", int'(score), 1);
    do_round(5, 0, 10, 0, "r3");
    check("r3_wrong_nonbcd", int'(wrong), 1);
    check("r3_score", int'(score), 1);
    check("r3_round", int'(round), 3);

    // Round 4: no submit; the verdict follows the 500th WAIT cycle.
    fix_val = 4'd9;
    wait_phase(M_WAIT, "r4");
    n = 1;
    while (timeout !== 1'b1 && n < 700) begin
      tick();
      n++;
    end
    check("r4_timeout_wait_cycles", n - 1, 500);
    check("r4_no_other_flag", int'({correct, wrong}), 0);

    do_round(11, 1, 1, 499, "r5");
    check("r5_race_correct", int'(correct), 1);
    check("r5_race_timeout", int'(timeout), 0);
    check("r5_score", int'(score), 2);

    fix_val = 4'd4;
    wait_phase(M_WAIT, "r6");
    start_btn = 1'b1;
    tick();
    start_btn = 1'b0;
    check("r6_start_ignored_lcg", int'(lcg_state), 2);
    ans_tens = 4'd0;
    ans_ones = 4'd4;
    submit_btn = 1'b1;
    tick();
    submit_btn = 1'b0;
    check("r6_round", int'(round), 6);

    do_round(15, 1, 5, 3, "r7");
    do_round(0, 0, 0, 1, "r8");
    wait_phase(M_DONE, "done");
    check("game_done", int'(done), 1);
    check("game_score", int'(score), 5);
    check("game_round", int'(round), 8);
    check("game_done_lcg", int'(lcg_state), 1);

    start_btn = 1'b1;
    tick();
    start_btn = 1'b0;
    check("restart_score", int'(score), 0);
    check("restart_round", int'(round), 0);
    check("restart_done", int'(done), 0);
    check("restart_latch_lcg", int'(lcg_state), 0);

    do_round(6, 0, 6, 0, "mid");
    check("mid_correct", int'(correct), 1);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_reset_values("midreset");
    submit_btn = 1'b1;
    tick();
    submit_btn = 1'b0;
    tick();
    check("midreset_idle_lcg", int'(lcg_state), 1);
    check("midreset_idle_flags", int'({correct, wrong, timeout}), 0);

    fix_en = 1'b0;
    for (int i = 0; i < 8000; i++) begin
      start_btn = ($urandom_range(0, 39) == 0);
      submit_btn = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 1) == 0) begin
        ans_tens = (m_q >= 10) ? 4'd1 : 4'd0;
        ans_ones = 4'(m_q % 10);
      end else begin
        ans_tens = 4'($urandom_range(0, 15));
        ans_ones = 4'($urandom_range(0, 15));
      end
      rst_n = ($urandom_range(0, 2999) != 0);
      tick();
    end
    start_btn = 1'b0;
    submit_btn = 1'b0;
    rst_n = 1'b1;
    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
